// File: rtl/io_frame_sched_pkg.sv
// Shared constants and types for the I/O frame scheduler.
// Channel counts and sample widths live here so the top and its bus interface agree.
package io_frame_sched_pkg;

    localparam int NUIOIN  = 4;      // input channels (width of req_in)
    localparam int NUIOOU  = 4;      // output channels (width of out_en)
    localparam int NBIN    = 19;     // signed input sample width
    localparam int NBOUT   = 28;     // signed output sample width
    localparam int TMO_DEF = 65535;  // default RUN watchdog limit in clk cycles

    // Frame phases: collect inputs, let the core run, push outputs downstream.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Sticky error bit positions.
    localparam int ERR_EMPTY = 0;   // core read a channel with no fresh sample
    localparam int ERR_MULTI = 1;   // multi-hot req_in or out_en strobe
    localparam int ERR_WDOG  = 2;   // RUN aborted by the watchdog

endpackage

// File: rtl/io_frame_sched_if.sv
// Bus bundle for the frame scheduler: input sample streams, core strobes and output streams.
// slave = the scheduler, master = the surrounding streams and core.
interface io_frame_sched_if #(
    parameter int NUIOIN = io_frame_sched_pkg::NUIOIN,
    parameter int NUIOOU = io_frame_sched_pkg::NUIOOU,
    parameter int NBIN   = io_frame_sched_pkg::NBIN,
    parameter int NBOUT  = io_frame_sched_pkg::NBOUT
);
    logic [NUIOIN-1:0]       s_valid;
    logic [NUIOIN*NBIN-1:0]  s_data;
    logic [NUIOIN-1:0]       s_ready;
    logic                    proc_rst;
    logic [NUIOIN-1:0]       req_in;
    logic [NBIN-1:0]         io_in;
    logic [NUIOOU-1:0]       out_en;
    logic [NBOUT-1:0]        io_out;
    logic [NUIOOU-1:0]       m_valid;
    logic [NUIOOU*NBOUT-1:0] m_data;
    logic [NUIOOU-1:0]       m_ready;

    modport slave (
        input  s_valid, s_data, req_in, out_en, io_out, m_ready,
        output s_ready, proc_rst, io_in, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, req_in, out_en, io_out, m_ready,
        input  s_ready, proc_rst, io_in, m_valid, m_data
    );
endinterface

// File: rtl/io_frame_sched_onehot_prio.sv
// Lowest-set-bit encoder for the core's one-hot strobes; also flags when more than one bit is set.
module io_frame_sched_onehot_prio #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any,
    output logic         o_multi
);
    // Scan high to low so the lowest set bit is the one left in o_idx.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
    end

    assign o_any   = |i_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_multi = |(i_vec & (i_vec - 1'b1));

endmodule

// File: rtl/io_frame_sched.sv
// Frame scheduler: buffers one sample per input channel, runs the core on a full frame,
// captures its outputs and drains them downstream before accepting the next frame.
module io_frame_sched
    import io_frame_sched_pkg::*;
#(
    parameter int TMO = TMO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    io_frame_sched_if.slave bus,
    output logic [15:0]     frame_cnt,
    output logic [2:0]      err
);
    localparam int WDW = $clog2(TMO + 1);
    localparam int IW  = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int OW  = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [NUIOIN-1:0] r_iflag;
    logic [NBIN-1:0]   r_hold [NUIOIN];
    logic [NUIOOU-1:0] r_oflag;
    logic [NBOUT-1:0]  r_obuf [NUIOOU];
    logic [WDW-1:0]    r_wd;
    logic [WDW-1:0]    w_wd_inc;
    logic              w_wd_hit;
    logic [15:0]       r_frame_cnt;
    logic [2:0]        r_err;

    logic [IW-1:0]     w_req_idx;
    logic              w_req_any;
    logic              w_req_multi;
    logic [OW-1:0]     w_out_idx;
    logic              w_out_any;
    logic              w_out_multi;
    logic [NBIN-1:0]   w_s_data [NUIOIN];

    io_frame_sched_onehot_prio #(.N(NUIOIN), .W(IW)) u_req_prio (
        .i_vec(bus.req_in), .o_idx(w_req_idx), .o_any(w_req_any), .o_multi(w_req_multi)
    );

    io_frame_sched_onehot_prio #(.N(NUIOOU), .W(OW)) u_out_prio (
        .i_vec(bus.out_en), .o_idx(w_out_idx), .o_any(w_out_any), .o_multi(w_out_multi)
    );

    // Unpack input lanes and pack output lanes.
    for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in_lane
        assign w_s_data[gi] = bus.s_data[gi*NBIN +: NBIN];
    end
    for (genvar gi = 0; gi < NUIOOU; gi++) begin : g_out_lane
        assign bus.m_data[gi*NBOUT +: NBOUT] = r_obuf[gi];
    end

    // Saturating watchdog; the abort fires on the edge where the count would reach TMO.
    assign w_wd_inc = (r_wd == WDW'(TMO)) ? r_wd : r_wd + 1'b1;
    assign w_wd_hit = (w_wd_inc == WDW'(TMO));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FILL;
        else     r_state <= w_state_next;
    end

    // Next state: completion checks use registered flags so the last strobe lands first.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:  if (&r_iflag) w_state_next = ST_RUN;
            ST_RUN:   if ((&r_oflag) || w_wd_hit) w_state_next = ST_DRAIN;
            ST_DRAIN: if (r_oflag == '0) w_state_next = ST_FILL;
            default:  w_state_next = ST_FILL;
        endcase
    end

    // Outputs: core held in reset outside RUN; io_in is a pure mux of the held samples.
    always_comb begin
        bus.s_ready  = (r_state == ST_FILL) ? ~r_iflag : '0;
        bus.proc_rst = (r_state != ST_RUN);
        bus.m_valid  = (r_state == ST_DRAIN) ? r_oflag : '0;
        bus.io_in    = (r_state == ST_RUN && w_req_any) ? r_hold[w_req_idx] : '0;
    end

    // Input side: load samples in FILL, consume on core reads, flush leftovers on DRAIN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iflag <= '0;
            for (int i = 0; i < NUIOIN; i++) r_hold[i] <= '0;
        end else if (r_state == ST_FILL) begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (bus.s_valid[i] && !r_iflag[i]) begin
                    r_hold[i]  <= w_s_data[i];
                    r_iflag[i] <= 1'b1;
                end
            end
        end else if (r_state == ST_RUN) begin
            if (w_state_next == ST_DRAIN) r_iflag <= '0;
            else if (w_req_any)           r_iflag[w_req_idx] <= 1'b0;
        end
    end

    // Output side: capture core writes in RUN, clear flags as downstream accepts in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oflag <= '0;
            for (int j = 0; j < NUIOOU; j++) r_obuf[j] <= '0;
        end else if (r_state == ST_RUN) begin
            if (w_out_any) begin
                r_obuf[w_out_idx]  <= bus.io_out;
                r_oflag[w_out_idx] <= 1'b1;
            end
        end else if (r_state == ST_DRAIN) begin
            r_oflag <= r_oflag & ~(bus.m_valid & bus.m_ready);
        end
    end

    // Watchdog, sticky errors and the completed-frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd        <= '0;
            r_err       <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                ST_FILL: if (&r_iflag) r_wd <= '0;
                ST_RUN: begin
                    r_wd <= w_wd_inc;
                    if (w_req_any && !r_iflag[w_req_idx]) r_err[ERR_EMPTY] <= 1'b1;
                    if (w_req_multi || w_out_multi)       r_err[ERR_MULTI] <= 1'b1;
                    if (!(&r_oflag) && w_wd_hit)          r_err[ERR_WDOG]  <= 1'b1;
                end
                ST_DRAIN: if (r_oflag == '0) r_frame_cnt <= r_frame_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err       = r_err;

endmodule

// File: tb/tb_io_frame_sched.sv
// Self-checking bench: directed frame scenarios plus randomized traffic, all compared each cycle
// against a frame-level behavioural model of the scheduler.
module tb_io_frame_sched;
    import io_frame_sched_pkg::*;

    localparam int TMO_TB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] frame_cnt;
    logic [2:0]  err;

    always #5 clk = ~clk;

    io_frame_sched_if bus_if ();

    io_frame_sched #(.TMO(TMO_TB)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .frame_cnt (frame_cnt),
        .err       (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    int               md_phase;            // 0 = collecting, 1 = core running, 2 = draining
    bit               md_in_full  [NUIOIN];
    logic [NBIN-1:0]  md_in_val   [NUIOIN];
    bit               md_out_full [NUIOOU];
    logic [NBOUT-1:0] md_out_val  [NUIOOU];
    int               md_run_cyc;
    int               md_frames;
    logic [2:0]       md_err;

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        md_phase = 0; md_run_cyc = 0; md_frames = 0; md_err = 3'b000;
        for (int i = 0; i < NUIOIN; i++) begin md_in_full[i] = 0; md_in_val[i] = '0; end
        for (int j = 0; j < NUIOOU; j++) begin md_out_full[j] = 0; md_out_val[j] = '0; end
    endtask

    task automatic model_compare();
        logic [NUIOIN-1:0]       e_srdy;
        logic [NUIOOU-1:0]       e_mv;
        logic [NBIN-1:0]         e_io;
        logic [NUIOOU*NBOUT-1:0] e_md;
        int k;
        for (int i = 0; i < NUIOIN; i++) e_srdy[i] = (md_phase == 0) && !md_in_full[i];
        for (int j = 0; j < NUIOOU; j++) begin
            e_mv[j] = (md_phase == 2) && md_out_full[j];
            e_md[j*NBOUT +: NBOUT] = md_out_val[j];
        end
        k = lowest_set(bus_if.req_in);
        e_io = (md_phase == 1 && k >= 0) ? md_in_val[k] : '0;
        check_val("s_ready",   bus_if.s_ready,  e_srdy);
        check_val("proc_rst",  bus_if.proc_rst, md_phase != 1);
        check_val("io_in",     bus_if.io_in,    e_io);
        check_val("m_valid",   bus_if.m_valid,  e_mv);
        check_val("m_data",    bus_if.m_data,   e_md);
        check_val("frame_cnt", frame_cnt,       16'(md_frames));
        check_val("err",       err,             md_err);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit all_in, all_out, any_out;
        int k, j;
        if (rst) begin model_reset(); return; end
        all_in = 1; all_out = 1; any_out = 0;
        for (int i = 0; i < NUIOIN; i++) if (!md_in_full[i]) all_in = 0;
        for (int i = 0; i < NUIOOU; i++) begin
            if (!md_out_full[i]) all_out = 0;
            if (md_out_full[i])  any_out = 1;
        end
        case (md_phase)
            0: begin
                if (all_in) begin
                    md_phase = 1; md_run_cyc = 0;
                end else begin
                    for (int i = 0; i < NUIOIN; i++)
                        if (bus_if.s_valid[i] && !md_in_full[i]) begin
                            md_in_full[i] = 1;
                            md_in_val[i]  = bus_if.s_data[i*NBIN +: NBIN];
                        end
                end
            end
            1: begin
                md_run_cyc++;
                k = lowest_set(bus_if.req_in);
                if (k >= 0) begin
                    if (!md_in_full[k]) md_err[0] = 1'b1;
                    if ($countones(bus_if.req_in) > 1) md_err[1] = 1'b1;
                    md_in_full[k] = 0;
                end
                j = lowest_set(bus_if.out_en);
                if (j >= 0) begin
                    if ($countones(bus_if.out_en) > 1) md_err[1] = 1'b1;
                    md_out_val[j]  = bus_if.io_out;
                    md_out_full[j] = 1;
                end
                if (all_out || md_run_cyc == TMO_TB) begin
                    if (!all_out) md_err[2] = 1'b1;
                    md_phase = 2;
                    for (int i = 0; i < NUIOIN; i++) md_in_full[i] = 0;
                end
            end
            default: begin
                if (!any_out) begin
                    md_phase = 0; md_frames++;
                end else begin
                    for (int i = 0; i < NUIOOU; i++)
                        if (bus_if.m_ready[i]) md_out_full[i] = 0;
                end
            end
        endcase
    endtask

    // One clock: compare at the falling edge, step the model, move to just after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus_if.s_valid = '0; bus_if.s_data = '0; bus_if.req_in = '0;
        bus_if.out_en = '0; bus_if.io_out = '0; bus_if.m_ready = '0;
    endtask

    task automatic fill_frame();
        for (int i = 0; i < NUIOIN; i++) bus_if.s_data[i*NBIN +: NBIN] = NBIN'($urandom);
        bus_if.s_valid = '1;
        tick();
        bus_if.s_valid = '0;
        tick();
    endtask

    function automatic logic [3:0] rand_strobe();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return 4'b0000;
        if (r < 85) return 4'(1 << $urandom_range(0, 3));
        return 4'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int last_frames;
        rst = 1'b1;
        set_idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_val("rst_proc_rst", bus_if.proc_rst, 1'b1);
        check_val("rst_s_ready",  bus_if.s_ready,  4'b1111);
        check_val("rst_frame",    frame_cnt,       16'd0);
        rst = 1'b0;

        // Full frame in one cycle, then core reads and writes.
        bus_if.s_valid = 4'b1111;
        bus_if.s_data  = {19'd4, 19'd3, 19'd2, 19'd1};
        tick();
        bus_if.s_valid = '0; #1;
        check_val("fill_s_ready_low", bus_if.s_ready,  4'b0000);
        check_val("fill_still_rst",   bus_if.proc_rst, 1'b1);
        tick();
        check_val("run_proc_rst", bus_if.proc_rst, 1'b0);
        $display("frame 1: core released from reset");
        bus_if.req_in = 4'b0100; #1;
        check_val("read_ch2", bus_if.io_in, 19'd3);
        tick();
        #1;
        check_val("reread_ch2", bus_if.io_in, 19'd3);
        tick();
        bus_if.req_in = '0; #1;
        check_val("err_empty", err, 3'b001);
        for (int j = 0; j < 4; j++) begin
            bus_if.out_en = 4'(1 << j);
            bus_if.io_out = 28'(10 * (j + 1));
            tick();
            $display("frame 1: core wrote ch%0d", j);
        end
        bus_if.out_en = '0;
        tick();
        check_val("drain_proc_rst", bus_if.proc_rst, 1'b1);
        check_val("drain_m_valid",  bus_if.m_valid,  4'b1111);
        check_val("drain_ch2_data", bus_if.m_data[2*NBOUT +: NBOUT], 28'd30);
        bus_if.m_ready = 4'b0101;
        tick();
        check_val("drain_half", bus_if.m_valid, 4'b1010);
        bus_if.m_ready = 4'b1010;
        tick();
        check_val("drain_done", bus_if.m_valid, 4'b0000);
        bus_if.m_ready = '0;
        tick();
        check_val("frame_cnt_1",  frame_cnt,      16'd1);
        check_val("refill_ready", bus_if.s_ready, 4'b1111);

        // Watchdog: only ch0 written, RUN lasts exactly TMO cycles.
        fill_frame();
        bus_if.out_en = 4'b0001; bus_if.io_out = 28'd77;
        tick();
        bus_if.out_en = '0;
        for (int c = 1; c < TMO_TB; c++) begin
            check_val("wdog_still_run", bus_if.proc_rst, 1'b0);
            tick();
        end
        check_val("wdog_err",     err[2],         1'b1);
        check_val("wdog_m_valid", bus_if.m_valid, 4'b0001);
        $display("frame 2: watchdog abort after %0d run cycles", TMO_TB);
        bus_if.m_ready = 4'b0001;
        tick();
        bus_if.m_ready = '0;
        tick();
        check_val("frame_cnt_2", frame_cnt, 16'd2);

        // Asynchronous reset in the middle of RUN.
        fill_frame();
        bus_if.out_en = 4'b0010; bus_if.io_out = 28'd5;
        tick();
        bus_if.out_en = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_val("arst_proc_rst", bus_if.proc_rst, 1'b1);
        check_val("arst_m_valid",  bus_if.m_valid,  4'b0000);
        check_val("arst_frame",    frame_cnt,       16'd0);
        check_val("arst_s_ready",  bus_if.s_ready,  4'b1111);
        bus_if.req_in = 4'b0011;
        tick();
        rst = 1'b0;
        tick();
        check_val("fill_req_ignored", err, 3'b000);
        bus_if.req_in = '0;
        $display("reset mid-run: restarted in fill");

        // Randomized traffic against the model.
        last_frames = md_frames;
        for (int c = 0; c < 3000; c++) begin
            bus_if.s_valid = 4'($urandom);
            for (int i = 0; i < NUIOIN; i++) bus_if.s_data[i*NBIN +: NBIN] = NBIN'($urandom);
            bus_if.req_in  = rand_strobe();
            bus_if.out_en  = rand_strobe();
            bus_if.io_out  = 28'($urandom);
            bus_if.m_ready = 4'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #1 model_reset();
                tick();
                rst = 1'b0;
                last_frames = 0;
                $display("random: reset pulse at cycle %0d", c);
                continue;
            end
            tick();
            if (md_frames != last_frames) begin
                $display("random: frame %0d done, err=%b", md_frames, md_err);
                last_frames = md_frames;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
